// File: rtl/inst_fetcher_pkg.sv
// Shared fetch/issue definitions: RV32 opcodes, fetch FSM encoding and
// instruction-format builders used when expanding compressed encodings.
package inst_fetcher_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM  = 2'd1;
    localparam logic [1:0] ST_WAIT_JALR = 2'd2;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

endpackage

// File: rtl/rvc_expander.sv
// Combinational RV32C (integer subset) to RV32I expander with control-flow flags.
// Illegal or reserved encodings, including all-zero, expand to a NOP with no flags set.
module rvc_expander
    import inst_fetcher_pkg::*;
(
    input  logic [15:0] inst_c,
    output logic [31:0] inst_x,
    output logic        illegal,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_branch
);

    logic [4:0]  rd_f, rs2_f, rdp, rs1p;
    logic [11:0] imm6_sx;
    logic [9:0]  a4spn_imm, a16_imm;
    logic [6:0]  lw_off;
    logic [7:0]  lwsp_off, swsp_off;
    logic [11:0] cj_off;
    logic [8:0]  cb_off;

    // Primed registers (rd'/rs1'/rs2') map to x8..x15.
    assign rd_f      = inst_c[11:7];
    assign rs2_f     = inst_c[6:2];
    assign rdp       = {2'b01, inst_c[4:2]};
    assign rs1p      = {2'b01, inst_c[9:7]};
    assign imm6_sx   = {{6{inst_c[12]}}, inst_c[12], inst_c[6:2]};
    assign a4spn_imm = {inst_c[10:7], inst_c[12:11], inst_c[5], inst_c[6], 2'b00};
    assign a16_imm   = {inst_c[12], inst_c[4:3], inst_c[5], inst_c[2], inst_c[6], 4'b0000};
    assign lw_off    = {inst_c[5], inst_c[12:10], inst_c[6], 2'b00};
    assign lwsp_off  = {inst_c[3:2], inst_c[12], inst_c[6:4], 2'b00};
    assign swsp_off  = {inst_c[8:7], inst_c[12:9], 2'b00};
    assign cj_off    = {inst_c[12], inst_c[8], inst_c[10:9], inst_c[6], inst_c[7],
                        inst_c[2], inst_c[11], inst_c[5:3], 1'b0};
    assign cb_off    = {inst_c[12], inst_c[6:5], inst_c[2], inst_c[11:10], inst_c[4:3], 1'b0};

    always_comb begin
        inst_x    = INST_NOP;
        illegal   = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        case (inst_c[1:0])
            2'b00: case (inst_c[15:13])
                3'b000: if (a4spn_imm == '0) illegal = 1'b1;
                        else inst_x = enc_i({2'b00, a4spn_imm}, 5'd2, 3'b000, rdp, OP_IMM);
                3'b010: inst_x = enc_i({5'b0, lw_off}, rs1p, 3'b010, rdp, OP_LOAD);
                3'b110: inst_x = enc_s({5'b0, lw_off}, rdp, rs1p, 3'b010, OP_STORE);
                default: illegal = 1'b1;
            endcase
            2'b01: case (inst_c[15:13])
                3'b000: inst_x = enc_i(imm6_sx, rd_f, 3'b000, rd_f, OP_IMM);
                3'b001: begin
                    inst_x = enc_j({{9{cj_off[11]}}, cj_off}, 5'd1, OP_JAL);
                    is_jal = 1'b1;
                end
                3'b010: inst_x = enc_i(imm6_sx, 5'd0, 3'b000, rd_f, OP_IMM);
                3'b011: begin
                    if (rd_f == 5'd2) begin
                        if (a16_imm == '0) illegal = 1'b1;
                        else inst_x = enc_i({{2{a16_imm[9]}}, a16_imm}, 5'd2, 3'b000, 5'd2, OP_IMM);
                    end else if ({inst_c[12], inst_c[6:2]} == '0) begin
                        illegal = 1'b1;
                    end else begin
                        inst_x = enc_u({{14{inst_c[12]}}, inst_c[12], inst_c[6:2]}, rd_f, OP_LUI);
                    end
                end
                3'b100: case (inst_c[11:10])
                    2'b00: if (inst_c[12]) illegal = 1'b1;
                           else inst_x = enc_i({7'b0, inst_c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
                    2'b01: if (inst_c[12]) illegal = 1'b1;
                           else inst_x = enc_i({7'b0100000, inst_c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
                    2'b10: inst_x = enc_i(imm6_sx, rs1p, 3'b111, rs1p, OP_IMM);
                    default: if (inst_c[12]) illegal = 1'b1;
                        else case (inst_c[6:5])
                            2'b00:   inst_x = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG);
                            2'b01:   inst_x = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG);
                            2'b10:   inst_x = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG);
                            default: inst_x = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG);
                        endcase
                endcase
                3'b101: begin
                    inst_x = enc_j({{9{cj_off[11]}}, cj_off}, 5'd0, OP_JAL);
                    is_jal = 1'b1;
                end
                3'b110: begin
                    inst_x    = enc_b({{4{cb_off[8]}}, cb_off}, 5'd0, rs1p, 3'b000, OP_BRANCH);
                    is_branch = 1'b1;
                end
                default: begin
                    inst_x    = enc_b({{4{cb_off[8]}}, cb_off}, 5'd0, rs1p, 3'b001, OP_BRANCH);
                    is_branch = 1'b1;
                end
            endcase
            2'b10: case (inst_c[15:13])
                3'b000: if (inst_c[12]) illegal = 1'b1;
                        else inst_x = enc_i({7'b0, inst_c[6:2]}, rd_f, 3'b001, rd_f, OP_IMM);
                3'b010: if (rd_f == 5'd0) illegal = 1'b1;
                        else inst_x = enc_i({4'b0, lwsp_off}, 5'd2, 3'b010, rd_f, OP_LOAD);
                3'b100: begin
                    if (!inst_c[12]) begin
                        if (rs2_f != 5'd0) begin
                            inst_x = enc_r(7'b0, rs2_f, 5'd0, 3'b000, rd_f, OP_REG);
                        end else if (rd_f == 5'd0) begin
                            illegal = 1'b1;
                        end else begin
                            inst_x  = enc_i(12'd0, rd_f, 3'b000, 5'd0, OP_JALR);
                            is_jalr = 1'b1;
                        end
                    end else begin
                        if (rs2_f != 5'd0) begin
                            inst_x = enc_r(7'b0, rs2_f, rd_f, 3'b000, rd_f, OP_REG);
                        end else if (rd_f == 5'd0) begin
                            inst_x = INST_EBREAK;
                        end else begin
                            inst_x  = enc_i(12'd0, rd_f, 3'b000, 5'd1, OP_JALR);
                            is_jalr = 1'b1;
                        end
                    end
                end
                3'b110: inst_x = enc_s({4'b0, swsp_off}, rs2_f, 5'd2, 3'b010, OP_STORE);
                default: illegal = 1'b1;
            endcase
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: PC owner, icache requester, static taken prediction, one push per fetch.
// Req one cycle after IDLE, push one cycle after icache_valid; _need_inst sampled only in IDLE.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic [31:0] _clear_pc,
    input  logic        _pc_sel,
    input  logic [31:0] _pc_sel_addr,
    input  logic        _need_inst,
    output logic        _icache_req,
    output logic [31:0] _icache_addr,
    input  logic        _icache_valid,
    input  logic [31:0] _icache_data,
    output logic        _inst_ready_out,
    output logic [31:0] _inst_out,
    output logic [31:0] _inst_addr_out,
    output logic        _rvc_out,
    output logic [31:0] _jalr_rd
);

    logic [1:0]  state_q, next_state;
    logic [31:0] pc_q, next_pc;
    logic        req_q;
    logic [31:0] addr_q;
    logic        push_q;
    logic [31:0] inst_q, inst_addr_q, jalr_rd_q;
    logic        rvc_q;

    logic        is_rvc, rvc_illegal, rvc_jal, rvc_jalr, rvc_branch;
    logic [31:0] rvc_inst, inst_w, len, imm_j, imm_b;
    logic        is_jal, is_jalr, is_branch;

    rvc_expander u_rvc_expander (
        .inst_c    (_icache_data[15:0]),
        .inst_x    (rvc_inst),
        .illegal   (rvc_illegal),
        .is_jal    (rvc_jal),
        .is_jalr   (rvc_jalr),
        .is_branch (rvc_branch)
    );

    assign is_rvc    = _icache_data[1:0] != 2'b11;
    assign inst_w    = is_rvc ? (rvc_illegal ? INST_NOP : rvc_inst) : _icache_data;
    assign len       = is_rvc ? 32'd2 : 32'd4;
    assign is_jal    = is_rvc ? rvc_jal    : (inst_w[6:0] == OP_JAL);
    assign is_jalr   = is_rvc ? rvc_jalr   : (inst_w[6:0] == OP_JALR);
    assign is_branch = is_rvc ? rvc_branch : (inst_w[6:0] == OP_BRANCH);

    // Immediates come from the expanded word so compressed jumps need no separate path.
    assign imm_j = {{11{inst_w[31]}}, inst_w[31], inst_w[19:12], inst_w[20], inst_w[30:21], 1'b0};
    assign imm_b = {{19{inst_w[31]}}, inst_w[31], inst_w[7], inst_w[30:25], inst_w[11:8], 1'b0};

    always_comb begin
        next_pc    = pc_q + len;
        next_state = ST_IDLE;
        if (is_jal)         next_pc = pc_q + imm_j;
        else if (is_branch) next_pc = pc_q + imm_b;
        else if (is_jalr)   next_state = ST_WAIT_JALR;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            push_q      <= 1'b0;
            inst_q      <= '0;
            inst_addr_q <= '0;
            rvc_q       <= 1'b0;
            jalr_rd_q   <= '0;
        end else if (!rdy_in) begin
            // Frozen: everything holds except the push pulse, which must not replay later.
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (_clear) begin
                pc_q    <= _clear_pc;
                state_q <= ST_IDLE;
                req_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (_need_inst) begin
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                        state_q <= ST_WAIT_MEM;
                    end
                    ST_WAIT_MEM: if (_icache_valid) begin
                        req_q       <= 1'b0;
                        push_q      <= 1'b1;
                        inst_q      <= inst_w;
                        inst_addr_q <= pc_q;
                        rvc_q       <= is_rvc;
                        pc_q        <= next_pc;
                        state_q     <= next_state;
                        if (is_jalr) jalr_rd_q <= pc_q + len;
                    end
                    ST_WAIT_JALR: if (_pc_sel) begin
                        pc_q    <= _pc_sel_addr;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign _icache_req    = req_q;
    assign _icache_addr   = addr_q;
    assign _inst_ready_out = push_q & rdy_in;
    assign _inst_out      = inst_q;
    assign _inst_addr_out = inst_addr_q;
    assign _rvc_out       = rvc_q;
    assign _jalr_rd       = jalr_rd_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed program walk through the fetcher; a monitor scores requests and pushes
// against expectations queued by the stimulus process.
module tb_inst_fetcher;

    localparam int K_NORM   = 0;
    localparam int K_JALR   = 1;
    localparam int K_CLEAR  = 2;
    localparam int K_FREEZE = 3;
    localparam int K_HOLD   = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] inst;
        logic        rvc;
        int          kind;
    } step_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        rvc;
    } push_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        _clear = 1'b0;
    logic [31:0] _clear_pc = '0;
    logic        _pc_sel = 1'b0;
    logic [31:0] _pc_sel_addr = '0;
    logic        _need_inst = 1'b0;
    logic        _icache_req;
    logic [31:0] _icache_addr;
    logic        _icache_valid = 1'b0;
    logic [31:0] _icache_data = '0;
    logic        _inst_ready_out;
    logic [31:0] _inst_out;
    logic [31:0] _inst_addr_out;
    logic        _rvc_out;
    logic [31:0] _jalr_rd;

    int checks = 0;
    int failures = 0;

    step_t       tbl[$];
    push_t       exp_push[$];
    logic [31:0] exp_req[$];

    inst_fetcher #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._clear_pc      (_clear_pc),
        ._pc_sel        (_pc_sel),
        ._pc_sel_addr   (_pc_sel_addr),
        ._need_inst     (_need_inst),
        ._icache_req    (_icache_req),
        ._icache_addr   (_icache_addr),
        ._icache_valid  (_icache_valid),
        ._icache_data   (_icache_data),
        ._inst_ready_out(_inst_ready_out),
        ._inst_out      (_inst_out),
        ._inst_addr_out (_inst_addr_out),
        ._rvc_out       (_rvc_out),
        ._jalr_rd       (_jalr_rd)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scores every push and every new request against the queues.
    initial begin
        logic  req_prev;
        push_t p;
        req_prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (_inst_ready_out) begin
                if (exp_push.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_push: got inst %h at %h, expected none", _inst_out, _inst_addr_out);
                end else begin
                    p = exp_push.pop_front();
                    chk("push_inst", _inst_out, p.inst);
                    chk("push_addr", _inst_addr_out, p.addr);
                    chk("push_rvc", {31'b0, _rvc_out}, {31'b0, p.rvc});
                end
            end
            if (_icache_req && !req_prev) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got addr %h, expected none", _icache_addr);
                end else begin
                    chk("req_addr", _icache_addr, exp_req.pop_front());
                end
            end
            req_prev = _icache_req;
        end
    end

    initial begin
        step_t e;
        logic  seen;
        logic  abort;
        abort = 1'b0;

        tbl.push_back('{32'h000, 32'h0050_0093, 32'h0050_0093, 1'b0, K_NORM});
        tbl.push_back('{32'h004, 32'h0000_0013, 32'h0000_0013, 1'b0, K_NORM});
        tbl.push_back('{32'h008, 32'h1234_4505, 32'h0010_0513, 1'b1, K_NORM});   // c.li a0,1
        tbl.push_back('{32'h00A, 32'h0000_A819, 32'h0160_006F, 1'b1, K_NORM});   // c.j +22
        tbl.push_back('{32'h020, 32'h0100_006F, 32'h0100_006F, 1'b0, K_NORM});   // jal +16
        tbl.push_back('{32'h030, 32'h0100_006F, 32'h0100_006F, 1'b0, K_NORM});
        tbl.push_back('{32'h040, 32'hFE00_0CE3, 32'hFE00_0CE3, 1'b0, K_NORM});   // beq -8
        tbl.push_back('{32'h038, 32'h0C80_006F, 32'h0C80_006F, 1'b0, K_NORM});   // jal +200
        tbl.push_back('{32'h100, 32'h0000_80E7, 32'h0000_80E7, 1'b0, K_JALR});
        tbl.push_back('{32'h200, 32'h0000_0013, 32'h0000_0013, 1'b0, K_CLEAR});
        tbl.push_back('{32'h080, 32'h0000_0013, 32'h0000_0013, 1'b0, K_FREEZE});
        tbl.push_back('{32'h084, 32'h0000_0000, 32'h0000_0013, 1'b1, K_NORM});   // illegal c.0
        tbl.push_back('{32'h086, 32'h0000_0013, 32'h0000_0013, 1'b0, K_HOLD});

        repeat (2) @(negedge clk_in);
        chk("rst_req", {31'b0, _icache_req}, 32'd0);
        chk("rst_addr", _icache_addr, 32'h0);
        chk("rst_ready", {31'b0, _inst_ready_out}, 32'd0);
        chk("rst_inst", _inst_out, 32'h0);
        chk("rst_inst_addr", _inst_addr_out, 32'h0);
        chk("rst_rvc", {31'b0, _rvc_out}, 32'd0);
        chk("rst_jalr_rd", _jalr_rd, 32'h0);
        rst_in = 1'b1;
        @(negedge clk_in);
        _need_inst = 1'b1;

        for (int i = 0; i < tbl.size() && !abort; i++) begin
            e = tbl[i];
            exp_req.push_back(e.addr);
            if (e.kind != K_CLEAR) exp_push.push_back('{e.inst, e.addr, e.rvc});

            if (e.kind == K_HOLD) begin
                repeat (3) begin
                    @(negedge clk_in);
                    chk("hold_no_req", {31'b0, _icache_req}, 32'd0);
                end
                _need_inst = 1'b1;
            end

            seen = 1'b0;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk_in);
                if (_icache_req) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL req_timeout step %0d: got no request, expected addr %h", i, e.addr);
                abort = 1'b1;
            end else begin
                if (e.kind == K_FREEZE) begin
                    // Response, flush and freeze all at once: the flush and data must be ignored.
                    rdy_in        = 1'b0;
                    _icache_valid = 1'b1;
                    _icache_data  = e.data;
                    _clear        = 1'b1;
                    _clear_pc     = 32'h300;
                    repeat (3) begin
                        @(negedge clk_in);
                        chk("freeze_req", {31'b0, _icache_req}, 32'd1);
                        chk("freeze_addr", _icache_addr, e.addr);
                    end
                    rdy_in        = 1'b1;
                    _icache_valid = 1'b0;
                    _clear        = 1'b0;
                end
                @(negedge clk_in);
                _icache_valid = 1'b1;
                _icache_data  = e.data;
                if (e.kind == K_CLEAR) begin
                    _clear    = 1'b1;
                    _clear_pc = 32'h080;
                end
                @(negedge clk_in);
                _icache_valid = 1'b0;
                _clear        = 1'b0;
                if (i == tbl.size() - 1 || tbl[i + 1].kind == K_HOLD) _need_inst = 1'b0;

                if (e.kind == K_JALR) begin
                    repeat (4) begin
                        @(negedge clk_in);
                        chk("jalr_no_req", {31'b0, _icache_req}, 32'd0);
                        chk("jalr_rd", _jalr_rd, 32'h104);
                    end
                    _pc_sel      = 1'b1;
                    _pc_sel_addr = 32'h200;
                    @(negedge clk_in);
                    _pc_sel = 1'b0;
                end
            end
        end

        repeat (4) @(negedge clk_in);
        chk("end_no_req", {31'b0, _icache_req}, 32'd0);
        chk("push_left", exp_push.size(), 32'd0);
        chk("req_left", exp_req.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
